// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions: flit type encodings (carried in the two MSBs of
// every flit), the allocator FSM state type, and small helpers for
// classifying flits.
// ---------------------------------------------------------------------------
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_TAIL      = 2'b01,
    FLIT_HEAD      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11   // single-flit packet
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  localparam int unsigned FLIT_TYPE_W = 2;
  localparam int unsigned PKT_CNT_W   = 16;

  // Callers pass the type field, i.e. flit[FLIT_WIDTH-1 -: FLIT_TYPE_W].
  function automatic flit_type_e flit_type(input logic [FLIT_TYPE_W-1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

  function automatic logic is_head(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
// Purely combinational round-robin pick: scans requests starting at
// i_priority and wrapping at N-1, grants the first one found.
// Ports:
//   i_requests  [N-1:0]      request vector
//   i_priority  [IDX_W-1:0]  index scanned first (must be < N)
//   o_grant     [N-1:0]      one-hot grant (zero when no request)
//   o_grant_idx [IDX_W-1:0]  index of the granted request
//   o_grant_vld              any request granted
// ---------------------------------------------------------------------------
module round_robin_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_requests,
  input  logic [IDX_W-1:0] i_priority,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_vld
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so prio + offset never overflows before the wrap.
      w_sum = {1'b0, i_priority} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
      w_idx = w_sum[IDX_W-1:0];
      if (!o_grant_vld && i_requests[w_idx]) begin
        o_grant_vld    = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// ---------------------------------------------------------------------------
// output_port_allocator
// Wormhole output-port allocator for one router output. While IDLE, inputs
// presenting a HEAD/HEAD_TAIL compete round-robin; a HEAD locks the port to
// its input until that input's TAIL passes, so packets never interleave.
// The output is a single registered stage with full throughput.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_valid/i_flit      per-input flit offer (type in flit MSBs)
//   o_ready             per-input accept
//   o_valid/o_flit      registered output flit
//   i_ready             downstream accept
//   o_pkt_count         packets passed (only with NOC_ALLOC_STATS_EN)
// Build option: `define NOC_ALLOC_STATS_EN adds the 16-bit packet counter.
// ---------------------------------------------------------------------------
module output_port_allocator
  import noc_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_INPUTS-1:0]                i_valid,
  input  logic [NUM_INPUTS-1:0][FLIT_WIDTH-1:0] i_flit,
  output logic [NUM_INPUTS-1:0]                o_ready,
  output logic                                 o_valid,
  output logic [FLIT_WIDTH-1:0]                o_flit,
  input  logic                                 i_ready
`ifdef NOC_ALLOC_STATS_EN
  ,output logic [PKT_CNT_W-1:0]                o_pkt_count
`endif
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS-1);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  alloc_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_owner, w_owner_nxt;
  logic [IDX_W-1:0]        r_prio,  w_prio_nxt;
  logic                    r_valid;
  logic [FLIT_WIDTH-1:0]   r_flit;

  logic [NUM_INPUTS-1:0]   w_head_req;
  logic [NUM_INPUTS-1:0]   w_grant;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_grant_vld;
  logic                    w_can_accept;
  logic [IDX_W-1:0]        w_sel_idx;
  logic [FLIT_WIDTH-1:0]   w_sel_flit;
  flit_type_e              w_sel_type;
  logic                    w_xfer;

  // Only packet starts compete; BODY/TAIL on a non-owner simply wait.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_req
    assign w_head_req[k] = i_valid[k] &&
                           is_head(flit_type(i_flit[k][FLIT_WIDTH-1 -: FLIT_TYPE_W]));
  end

  round_robin_arbiter #(.N(NUM_INPUTS), .IDX_W(IDX_W)) u_arb (
    .i_requests  (w_head_req),
    .i_priority  (r_prio),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // Output register can take a flit if empty or draining this cycle.
  assign w_can_accept = !r_valid || i_ready;

  always_comb begin
    o_ready = '0;
    if (r_state == ST_IDLE) begin
      if (w_grant_vld && w_can_accept) o_ready = w_grant;
    end else begin
      o_ready[r_owner] = w_can_accept;
    end
  end

  // At most one o_ready bit is set, so the selected input is the transfer.
  assign w_sel_idx  = (r_state == ST_IDLE) ? w_grant_idx : r_owner;
  assign w_sel_flit = i_flit[w_sel_idx];
  assign w_sel_type = flit_type(w_sel_flit[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
  assign w_xfer     = |(i_valid & o_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_type == FLIT_HEAD) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_grant_idx;
          end else if (w_sel_type == FLIT_HEAD_TAIL) begin
            w_prio_nxt = next_idx(w_grant_idx);
          end
        end
        ST_LOCKED: begin
          if (w_sel_type == FLIT_TAIL) begin
            w_state_nxt = ST_IDLE;
            w_prio_nxt  = next_idx(r_owner);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_prio  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_flit  <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_flit  <= w_sel_flit;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_flit  = r_flit;

`ifdef NOC_ALLOC_STATS_EN
  logic [PKT_CNT_W-1:0] r_pkt_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         r_pkt_count <= '0;
    else if (w_xfer && is_tail(w_sel_type)) r_pkt_count <= r_pkt_count + 1'b1;
  end

  assign o_pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// ---------------------------------------------------------------------------
// tb_output_port_allocator
// Directed bench: per-input source queues feed the DUT, expected output flits
// are pushed in hand-derived order and a negedge monitor pops and compares
// every output transfer. o_ready and a few internal registers are checked
// at specific cycles.
// ---------------------------------------------------------------------------
module tb_output_port_allocator;
  import noc_pkg::*;

  localparam int N  = 5;
  localparam int FW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         valid;
  logic [N-1:0][FW-1:0] flit;
  logic [N-1:0]         ready_o;
  logic                 ovalid;
  logic [FW-1:0]        oflit;
  logic                 iready;
`ifdef NOC_ALLOC_STATS_EN
  logic [15:0]          pkt_count;
`endif

  output_port_allocator #(.NUM_INPUTS(N), .FLIT_WIDTH(FW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_flit  (flit),
    .o_ready (ready_o),
    .o_valid (ovalid),
    .o_flit  (oflit),
    .i_ready (iready)
`ifdef NOC_ALLOC_STATS_EN
    ,.o_pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [FW-1:0] src_q[N][$];
  logic [FW-1:0] exp_q[$];

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int src, input int seq);
    return {t, 6'd0, 8'(src), 16'(seq)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output transfer must match the next expected flit.
  always @(negedge clk) begin
    if (rst_n && ovalid && iready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got %h expected none", oflit);
      end else begin
        check("out_flit", oflit, exp_q.pop_front());
      end
    end
  end

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      valid[k] = (src_q[k].size() != 0);
      flit[k]  = valid[k] ? src_q[k][0] : '0;
    end
  endtask

  task automatic load(input int k, input flit_type_e t, input int seq);
    src_q[k].push_back(mk(t, k, seq));
    drive();
  endtask

  task automatic expect_out(input int k, input flit_type_e t, input int seq);
    exp_q.push_back(mk(t, k, seq));
  endtask

  // One clock: optionally check o_ready mid-cycle, then retire accepted flits.
  task automatic step(input logic [N-1:0] exp_rdy, input bit chk, input string name);
    logic [N-1:0] acc;
    @(negedge clk);
    if (chk) check(name, 32'(ready_o), 32'(exp_rdy));
    acc = valid & ready_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) void'(src_q[k].pop_front());
    drive();
  endtask

  function automatic bit busy();
    bit b = ovalid || (exp_q.size() != 0);
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int bound, input string name);
    int cyc = 0;
    iready = 1'b1;
    while (busy() && cyc < bound) begin
      step('0, 1'b0, "");
      cyc++;
    end
    n_cmp++;
    if (busy()) begin
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, %0d flits expected", name, cyc, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    iready = 1'b1;
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    iready = 1'b1;
    valid  = '0;
    flit   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(ovalid), 32'd0);
    check("rst_o_flit",  oflit, 32'd0);
    check("rst_o_ready", 32'(ready_o), 32'd0);
    check("rst_prio",    32'(dut.r_prio), 32'd0);
    rst_n = 1'b1;

    // Single-flit packet on input 2.
    load(2, FLIT_HEAD_TAIL, 7);
    expect_out(2, FLIT_HEAD_TAIL, 7);
    step(5'b00100, 1'b1, "t1_rdy");
    check("t1_o_valid", 32'(ovalid), 32'd1);
    check("t1_o_flit",  oflit, mk(FLIT_HEAD_TAIL, 2, 7));
    check("t1_prio",    32'(dut.r_prio), 32'd3);
    drain(20, "t1_drain");

    // Inputs 0 and 3 contend from prio 0; 0's packet goes through whole.
    do_reset();
    load(0, FLIT_HEAD, 0); load(0, FLIT_BODY, 1); load(0, FLIT_BODY, 2); load(0, FLIT_TAIL, 3);
    load(3, FLIT_HEAD, 0); load(3, FLIT_TAIL, 1);
    expect_out(0, FLIT_HEAD, 0); expect_out(0, FLIT_BODY, 1);
    expect_out(0, FLIT_BODY, 2); expect_out(0, FLIT_TAIL, 3);
    expect_out(3, FLIT_HEAD, 0); expect_out(3, FLIT_TAIL, 1);
    step(5'b00001, 1'b1, "t2_rdy_0h");
    step(5'b00001, 1'b1, "t2_rdy_0b1");
    step(5'b00001, 1'b1, "t2_rdy_0b2");
    step(5'b00001, 1'b1, "t2_rdy_0t");
    step(5'b01000, 1'b1, "t2_rdy_3h");
    step(5'b01000, 1'b1, "t2_rdy_3t");
    check("t2_prio", 32'(dut.r_prio), 32'd4);
    drain(20, "t2_drain");

    // prio 4: input 4 first, then 0; prio wraps 4->0->1.
    load(4, FLIT_HEAD, 0); load(4, FLIT_TAIL, 1);
    load(0, FLIT_HEAD, 4); load(0, FLIT_BODY, 5); load(0, FLIT_TAIL, 6);
    expect_out(4, FLIT_HEAD, 0); expect_out(4, FLIT_TAIL, 1);
    expect_out(0, FLIT_HEAD, 4); expect_out(0, FLIT_BODY, 5); expect_out(0, FLIT_TAIL, 6);
    step(5'b10000, 1'b1, "t3_rdy_4h");
    step(5'b10000, 1'b1, "t3_rdy_4t");
    check("t3_prio_wrap", 32'(dut.r_prio), 32'd0);
    step(5'b00001, 1'b1, "t3_rdy_0h");
    step(5'b00001, 1'b1, "t3_rdy_0b");
    step(5'b00001, 1'b1, "t3_rdy_0t");
    check("t3_prio_after", 32'(dut.r_prio), 32'd1);
    drain(20, "t3_drain");

    // Downstream stall for 3 cycles while locked on input 1.
    load(1, FLIT_HEAD, 0); load(1, FLIT_BODY, 1); load(1, FLIT_BODY, 2); load(1, FLIT_TAIL, 3);
    expect_out(1, FLIT_HEAD, 0); expect_out(1, FLIT_BODY, 1);
    expect_out(1, FLIT_BODY, 2); expect_out(1, FLIT_TAIL, 3);
    step(5'b00010, 1'b1, "t4_rdy_1h");
    iready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(5'b00000, 1'b1, "t4_rdy_stall");
      check("t4_flit_hold",  oflit, mk(FLIT_HEAD, 1, 0));
      check("t4_valid_hold", 32'(ovalid), 32'd1);
    end
    iready = 1'b1;
    step(5'b00010, 1'b1, "t4_rdy_1b1");
    step(5'b00010, 1'b1, "t4_rdy_1b2");
    step(5'b00010, 1'b1, "t4_rdy_1t");
    drain(20, "t4_drain");

    // Reset mid-packet on input 2; the lock and output flit are discarded.
    iready = 1'b0;
    load(2, FLIT_HEAD, 0); load(2, FLIT_BODY, 1); load(2, FLIT_TAIL, 2);
    step(5'b00100, 1'b1, "t5_rdy_2h");
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(ovalid), 32'd0);
    check("t5_rst_flit",  oflit, 32'd0);
    check("t5_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("t5_rst_prio",  32'(dut.r_prio), 32'd0);
    rst_n  = 1'b1;
    iready = 1'b1;
    step(5'b00000, 1'b1, "t5_body_held1");
    step(5'b00000, 1'b1, "t5_body_held2");
    check("t5_no_out", 32'(ovalid), 32'd0);
    src_q[2].delete();
    drive();

    // Back-to-back single-flit packets; a stray BODY on input 3 never requests.
    load(0, FLIT_HEAD_TAIL, 1); load(1, FLIT_HEAD_TAIL, 1);
    load(4, FLIT_HEAD_TAIL, 1); load(3, FLIT_BODY, 9);
    expect_out(0, FLIT_HEAD_TAIL, 1); expect_out(1, FLIT_HEAD_TAIL, 1);
    expect_out(4, FLIT_HEAD_TAIL, 1);
    step(5'b00001, 1'b1, "t6_rdy_0");
    step(5'b00010, 1'b1, "t6_rdy_1");
    check("t6_valid_stream", 32'(ovalid), 32'd1);
    step(5'b10000, 1'b1, "t6_rdy_4");
    check("t6_prio", 32'(dut.r_prio), 32'd0);
    step(5'b00000, 1'b1, "t6_body_idle");
    src_q[3].delete();
    drive();
    drain(20, "t6_drain");

`ifdef NOC_ALLOC_STATS_EN
    check("stat_count3", 32'(pkt_count), 32'd3);
    // 65533 more single-flit packets take the counter 3 -> 0xFFFF -> 0.
    for (int i = 0; i < 65533; i++) begin
      src_q[0].push_back(mk(FLIT_HEAD_TAIL, 0, i));
      exp_q.push_back(mk(FLIT_HEAD_TAIL, 0, i));
    end
    drive();
    drain(70000, "stat_drain");
    check("stat_wrap", 32'(pkt_count), 32'd0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_port_allocator.md
OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5: number of competing input ports.
REQ-002 SHALL have parameter FLIT_WIDTH, default 32: flit width in bits; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state is rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, NUM_INPUTS: per-input flit valid.
REQ-006 SHALL have port i_flit, input, NUM_INPUTS x FLIT_WIDTH: per-input flit data.
REQ-007 SHALL have port o_ready, output, NUM_INPUTS: per-input accept; transfer on input k = i_valid[k] && o_ready[k].
REQ-008 SHALL have port o_valid, output, 1: registered output flit valid.
REQ-009 SHALL have port o_flit, output, FLIT_WIDTH: registered output flit.
REQ-010 SHALL have port i_ready, input, 1: downstream accept; output transfer = o_valid && i_ready.

Function
REQ-011 SHALL decode flit type: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11 (single-flit packet).
REQ-012 SHALL implement states IDLE and LOCKED plus registers owner (clog2(NUM_INPUTS) bits) and prio (same width).
REQ-013 SHALL define can_accept = !o_valid || i_ready.
REQ-014 In IDLE SHALL arbitrate round-robin from prio over inputs with i_valid && type in {HEAD, HEAD_TAIL}; winner w gets o_ready[w] = can_accept, all others 0.
REQ-015 On HEAD transfer from w in IDLE SHALL set owner<=w, state<=LOCKED; prio unchanged.
REQ-016 On HEAD_TAIL transfer from w in IDLE SHALL stay IDLE and set prio<=(w+1) mod NUM_INPUTS.
REQ-017 In LOCKED SHALL drive o_ready[owner] = can_accept, all others 0, regardless of other inputs' flit types.
REQ-018 On TAIL transfer from owner in LOCKED SHALL set state<=IDLE, prio<=(owner+1) mod NUM_INPUTS; wrap from NUM_INPUTS-1 to 0.
REQ-019 Every upstream transfer SHALL load o_flit<=flit, o_valid<=1 the next edge: latency exactly 1 cycle.
REQ-020 Output transfer with no simultaneous upstream transfer SHALL clear o_valid; simultaneous output and upstream transfer SHALL replace o_flit with o_valid held 1 (full throughput, one flit/cycle).
REQ-021 With o_valid=1 and i_ready=0, o_flit/o_valid SHALL hold and all o_ready SHALL be 0.
REQ-022 Non-head flits presented by non-owners SHALL be held (not accepted, not dropped); a BODY/TAIL on any input while IDLE SHALL not request.
REQ-023 A new packet SHALL be granted in the cycle after a TAIL transfer at the earliest; packets never interleave on o_flit.

Reset
REQ-024 i_rst_n low SHALL asynchronously force state=IDLE, owner=0, prio=0, o_valid=0, o_flit=0; o_ready then derives from IDLE rules.
REQ-025 Reset mid-packet SHALL discard the lock and the output register; no recovery of partial packets.

Configuration
REQ-026 With NOC_ALLOC_STATS_EN defined SHALL add output o_pkt_count (16 bits, reset 0) incremented on every TAIL or HEAD_TAIL upstream transfer, wrapping 16'hFFFF->0.
REQ-027 Without NOC_ALLOC_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Flit type typedef enum and the four encodings SHALL live in shared package noc_pkg, with a helper extracting type from a flit.
REQ-029 Grant selection SHALL instantiate the existing round_robin_arbiter sub-module (i_requests=head requests, i_priority=prio); no other sub-modules.

Verification
REQ-030 Reset, then i_valid[2]=1 HEAD_TAIL, i_ready=1 -> o_ready=5'b00100, next cycle o_valid=1 with that flit, prio=3.
REQ-031 Inputs 0 and 3 both HEAD, prio=0 -> input 0 granted; input 3 o_ready=0 through 0's BODY,BODY,TAIL; input 3 granted the cycle after TAIL; order on o_flit 0H,0B,0B,0T,3H.
REQ-032 prio=4, inputs 4 and 0 complete packets -> prio goes 4->0 after input 4 TAIL, then 0->1; verifies wrap.
REQ-033 Locked on input 1, i_ready=0 for 3 cycles -> o_flit stable, o_ready all 0; i_ready=1 resumes, no flit lost or duplicated.
REQ-034 Assert i_rst_n=0 mid-packet (after HEAD, before TAIL) -> o_valid=0 immediately, state IDLE, prio=0; a BODY on the former owner is not accepted after release.
REQ-035 With NOC_ALLOC_STATS_EN, 3 packets (one HEAD_TAIL, two multi-flit) -> o_pkt_count=3; preload near 16'hFFFF to check wrap to 0.
